sd_cmd_sched: RTL

- Round-robin scheduler that shares the SD command-line transmitter between two requesters: req 0 is the card-init FSM, req 1 is the data-transfer FSM.
- For the granted request it latches index and argument and computes CRC7 serially.
- It drives the transmitter's level tx_valid/tx_cmd handshake, then optionally waits for the response receiver with a timeout.
- It reports completion and status to the granted requester.

---
 rtl/sd_cmd_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_sched.sv
// Round-robin owner of the SD command line: grants one of two requesters,
// builds the CRC7-protected frame, drives the transmitter, awaits the response.
module sd_cmd_sched #(
  parameter int TO_W   = 10,
  parameter int TO_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [5:0]  idx0,
  input  logic [31:0] arg0,
  input  logic        rexp0,
  input  logic        req1,
  input  logic [5:0]  idx1,
  input  logic [31:0] arg1,
  input  logic        rexp1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [1:0]  status,
  output logic        busy,
  output logic        tx_valid,
  output logic [47:0] tx_cmd,
  input  logic        tx_over,
  output logic        rsp_arm,
  input  logic        rsp_valid,
  input  logic        rsp_crc_err
);

  typedef enum logic [2:0] {IDLE, CRC, SEND, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       arg_q, arg_d;
  logic              rexp_q, rexp_d;
  logic [6:0]        crc_q, crc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [47:0]       tx_cmd_q, tx_cmd_d;
  logic              tx_valid_q, tx_valid_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [1:0]        status_q, status_d;
  logic              rsp_arm_q, rsp_arm_d;

  logic [39:0]       frame;
  logic              bit_in;
  logic              fb;
  logic [6:0]        crc_nx;
  logic              win;

  assign frame  = {2'b01, idx_q, arg_q};
  assign bit_in = frame[6'd39 - cnt_q];
  assign fb     = bit_in ^ crc_q[6];
  assign crc_nx = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    rexp_d     = rexp_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    tx_cmd_d   = tx_cmd_q;
    tx_valid_d = tx_valid_q;
    status_d   = status_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    rsp_arm_d  = 1'b0;
    win        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // on a tie the requester not served last wins
          win     = (req0 & req1) ? ~last_q : req1;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          idx_d   = win ? idx1 : idx0;
          arg_d   = win ? arg1 : arg0;
          rexp_d  = win ? rexp1 : rexp0;
          crc_d   = 7'd0;
          cnt_d   = 6'd0;
          state_d = CRC;
        end
      end
      CRC: begin
        if (cnt_q == 6'd40) begin
          tx_cmd_d   = {frame, crc_q, 1'b1};
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else begin
          crc_d = crc_nx;
          cnt_d = cnt_q + 6'd1;
        end
      end
      SEND: begin
        if (tx_over) begin
          tx_valid_d = 1'b0;
          if (rexp_q) begin
            rsp_arm_d = 1'b1;
            to_d      = '0;
            state_d   = WAIT;
          end else begin
            status_d = 2'd0;
            done0_d  = ~owner_q;
            done1_d  = owner_q;
            state_d  = DONE;
          end
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          status_d = rsp_crc_err ? 2'd2 : 2'd0;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = DONE;
        end else if (to_q == TO_W'(TO_CYC - 1)) begin
          status_d = 2'd1;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      idx_q      <= '0;
      arg_q      <= '0;
      rexp_q     <= 1'b0;
      crc_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      tx_cmd_q   <= 48'hFFFF_FFFF_FFFF;
      tx_valid_q <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      status_q   <= 2'd0;
      rsp_arm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      rexp_q     <= rexp_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_valid_q <= tx_valid_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      status_q   <= status_d;
      rsp_arm_q  <= rsp_arm_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign status   = status_q;
  assign busy     = (state_q != IDLE);
  assign tx_valid = tx_valid_q;
  assign tx_cmd   = tx_cmd_q;
  assign rsp_arm  = rsp_arm_q;

endmodule
